// File: rtl/i2s_sample_fifo.sv
// ---------------------------------------------------------------------------
// i2s_sample_fifo
// Synchronous show-ahead FIFO for stereo sample pairs in the sck domain.
// The head entry appears on rd_data whenever empty=0, so a pop and its data
// are consumed in the same cycle. The occupancy count is a register.
//
// Ports
//   clk      in   bit clock, posedge
//   rst      in   async active-high reset (clears pointers and count)
//   wr_en    in   write request; ignored when full
//   wr_data  in   entry to write
//   rd_en    in   pop request; ignored when empty
//   rd_data  out  head entry (valid while empty=0)
//   empty    out  count == 0
//   full     out  count == DEPTH
//   count    out  occupancy in entries
// ---------------------------------------------------------------------------
module i2s_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_wr;
  logic              do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];
  assign count   = cnt_q;

  // Storage carries no reset; stale entries are never visible because the
  // count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_sample_feeder.sv
// ---------------------------------------------------------------------------
// i2s_tx_sample_feeder
// Stereo sample buffer feeding an I2S transmitter, in the sck domain.
// Pairs arrive over valid/ready and are queued. The current pair is held on
// ldata/rdata and advances only on an r_req edge, so the transmitter always
// samples stable words. Output stays muted until START_LEVEL pairs are
// queued, and drops back to muted on underrun rather than replaying data.
//
// Ports
//   sck        in   bit clock, all logic on posedge
//   rst        in   async active-high reset
//   in_ldata   in   left sample of incoming pair
//   in_rdata   in   right sample of incoming pair
//   in_valid   in   pair offered
//   in_ready   out  pair accepted when in_valid & in_ready
//   ldata      out  left sample to transmitter (registered)
//   rdata      out  right sample to transmitter (registered)
//   l_req      in   transmitter loading left word (no action needed)
//   r_req      in   transmitter loading right word; advance edge
//   level      out  FIFO occupancy in pairs
//   running    out  1 in RUN state
//   underrun   out  sticky underrun flag
//   urun_cnt   out  saturating underrun event count
//   clr_stat   in   synchronous clear of underrun / urun_cnt
//
// state | meaning
// ------+-------------------------------------------------------------
// PRIME | muted; zeros loaded at each advance, waiting for START_LEVEL
// RUN   | each advance pops the head pair; empty at advance -> underrun
// ---------------------------------------------------------------------------
module i2s_tx_sample_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 4
) (
  input  logic                    sck,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_ldata,
  input  logic [DATA_WIDTH-1:0]   in_rdata,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   ldata,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    l_req,
  input  logic                    r_req,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    running,
  output logic                    underrun,
  output logic [15:0]             urun_cnt,
  input  logic                    clr_stat
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  localparam logic ST_PRIME = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic                      state_q;
  logic                      state_d;
  logic                      push;
  logic                      pop;
  logic                      load_zero;
  logic                      urun_evt;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [2*DATA_WIDTH-1:0]   fifo_head;
  logic [LVL_W-1:0]          fifo_count;

  // The left-word load needs no action: ldata is already stable from the
  // previous advance. A coincident l_req/r_req is handled purely by r_req.
  logic unused_l_req;
  assign unused_l_req = l_req;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign level    = fifo_count;
  assign running  = (state_q == ST_RUN);

  i2s_sample_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sck),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({in_ldata, in_rdata}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // An empty FIFO at the advance is an underrun even if a pair is being
  // pushed in the same cycle; that pair is not bypassed to the output.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_zero = 1'b0;
    urun_evt  = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (r_req) begin
          load_zero = 1'b1;
        end
        if (fifo_count >= LVL_W'(START_LEVEL)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_req) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            load_zero = 1'b1;
            urun_evt  = 1'b1;
            state_d   = ST_PRIME;
          end
        end
      end
      default: begin
        state_d = ST_PRIME;
      end
    endcase
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      ldata <= '0;
      rdata <= '0;
    end else if (pop) begin
      ldata <= fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
      rdata <= fifo_head[DATA_WIDTH-1:0];
    end else if (load_zero) begin
      ldata <= '0;
      rdata <= '0;
    end
  end

  // An underrun coinciding with clr_stat counts as the first event after
  // the clear, so the count restarts at 1 rather than being lost.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
      urun_cnt <= '0;
    end else if (urun_evt) begin
      underrun <= 1'b1;
      if (clr_stat) begin
        urun_cnt <= 16'd1;
      end else if (urun_cnt != 16'hFFFF) begin
        urun_cnt <= urun_cnt + 16'd1;
      end
    end else if (clr_stat) begin
      underrun <= 1'b0;
      urun_cnt <= '0;
    end
  end

endmodule
